// File: rtl/ssd_value_formatter_if.sv
// ssd_value_formatter_if: start/busy/done bus carrying a signed value in and per-display 5-bit character codes out
interface ssd_value_formatter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [5*DIGITS-1:0]   digit_codes;
  modport master (output start, value, input busy, done, ovf, digit_codes);
  modport slave  (input start, value, output busy, done, ovf, digit_codes);
endinterface

// File: rtl/ssd_value_formatter.sv
// ssd_value_formatter: double-dabble signed value to SSD codes (clk, reset, bus: start/value in, busy/done/ovf/digit_codes out)
module ssd_value_formatter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  ssd_value_formatter_if.slave bus
);
  localparam int NB = (WIDTH + 3) / 3;
  localparam int PN = NB > DIGITS ? NB : DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] MINUS = 5'h0D;
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t              state, state_n;
  logic                sign, sign_n, sgn, ovf_n;
  logic [WIDTH-1:0]    mag, mag_n;
  logic [4*NB-1:0]     bcd, bcd_n, adj;
  logic [4*PN-1:0]     bpad;
  logic [CW-1:0]       cnt, cnt_n;
  logic [5*DIGITS-1:0] codes, codes_n;
  logic                ovf, done;
  int                  n;
  assign bus.busy        = state != IDLE;
  assign bus.done        = done;
  assign bus.ovf         = ovf;
  assign bus.digit_codes = codes;
  always_comb begin
    for (int i = 0; i < NB; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bpad = (4*PN)'(bcd);
    n = 1;
    for (int i = 0; i < PN; i++)
      if (bpad[4*i +: 4] != 4'd0) n = i + 1;
    sgn = sign && (bcd != '0);
    ovf_n = n + (sgn ? 1 : 0) > DIGITS;
    for (int i = 0; i < DIGITS; i++)
      codes_n[5*i +: 5] = ovf_n ? MINUS : i < n ? {1'b0, bpad[4*i +: 4]} : (sgn && i == n) ? MINUS : BLANK;
  end
  always_comb begin
    state_n = state;
    sign_n  = sign;
    mag_n   = mag;
    bcd_n   = bcd;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.start) begin
        sign_n  = bus.value[WIDTH-1];
        mag_n   = bus.value[WIDTH-1] ? -bus.value : bus.value;
        bcd_n   = '0;
        cnt_n   = CW'(WIDTH);
        state_n = SHIFT;
      end
      SHIFT: begin
        {bcd_n, mag_n} = {adj, mag} << 1;
        cnt_n   = cnt - CW'(1);
        state_n = cnt == CW'(1) ? FORMAT : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      codes <= {DIGITS{BLANK}};
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sign  <= sign_n;
      mag   <= mag_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      done  <= state == FORMAT;
      if (state == FORMAT) begin
        codes <= codes_n;
        ovf   <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_ssd_value_formatter.sv
// tb_ssd_value_formatter: directed self-checking bench for six- and four-display formatter instances
module tb_ssd_value_formatter;
  localparam logic [4:0] B = 5'h10;
  localparam logic [4:0] M = 5'h0D;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  ssd_value_formatter_if #(.WIDTH(16), .DIGITS(6)) bus6();
  ssd_value_formatter_if #(.WIDTH(16), .DIGITS(4)) bus4();
  ssd_value_formatter #(.WIDTH(16), .DIGITS(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  ssd_value_formatter #(.WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  always #5 clk = ~clk;
  task automatic run(input bit four, input logic [15:0] v, output int lat, output int bc);
    @(negedge clk);
    if (four) begin bus4.start = 1'b1; bus4.value = v; end
    else begin bus6.start = 1'b1; bus6.value = v; end
    @(posedge clk);
    #1;
    bc = four ? int'(bus4.busy) : int'(bus6.busy);
    bus4.start = 1'b0;
    bus6.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (four ? bus4.done : bus6.done) break;
      bc += four ? int'(bus4.busy) : int'(bus6.busy);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus6.digit_codes !== {6{B}}) $display("FAIL reset_codes got %h want %h", bus6.digit_codes, {6{B}}); else passed++;
    total++; if ({bus6.busy, bus6.done, bus6.ovf} !== 3'b000) $display("FAIL reset_flags busy/done/ovf got %b want 000", {bus6.busy, bus6.done, bus6.ovf}); else passed++;
    total++; if (bus4.digit_codes !== {4{B}}) $display("FAIL reset_codes4 got %h want %h", bus4.digit_codes, {4{B}}); else passed++;
  endtask
  task automatic test_basic;
    int lat, bc;
    run(1'b0, 16'd1234, lat, bc);
    total++; if (lat != 17) $display("FAIL latency_1234 got %0d want 17", lat); else passed++;
    total++; if (bc != 17) $display("FAIL busy_cycles got %0d want 17", bc); else passed++;
    total++; if (bus6.busy !== 1'b0) $display("FAIL busy_at_done got %b want 0", bus6.busy); else passed++;
    total++; if (bus6.digit_codes !== {B, B, 5'd1, 5'd2, 5'd3, 5'd4}) $display("FAIL codes_1234 got %h want %h", bus6.digit_codes, {B, B, 5'd1, 5'd2, 5'd3, 5'd4}); else passed++;
    total++; if (bus6.ovf !== 1'b0) $display("FAIL ovf_1234 got %b want 0", bus6.ovf); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus6.done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", bus6.done); else passed++;
    total++; if (bus6.digit_codes !== {B, B, 5'd1, 5'd2, 5'd3, 5'd4}) $display("FAIL codes_hold got %h want %h", bus6.digit_codes, {B, B, 5'd1, 5'd2, 5'd3, 5'd4}); else passed++;
  endtask
  task automatic test_sign_zero;
    int lat, bc;
    run(1'b0, -16'sd45, lat, bc);
    total++; if (bus6.digit_codes !== {B, B, B, M, 5'd4, 5'd5}) $display("FAIL codes_m45 got %h want %h", bus6.digit_codes, {B, B, B, M, 5'd4, 5'd5}); else passed++;
    run(1'b0, 16'd0, lat, bc);
    total++; if (bus6.digit_codes !== {B, B, B, B, B, 5'd0}) $display("FAIL codes_zero got %h want %h", bus6.digit_codes, {B, B, B, B, B, 5'd0}); else passed++;
  endtask
  task automatic test_extremes;
    int lat, bc;
    run(1'b0, 16'h8000, lat, bc);
    total++; if (bus6.digit_codes !== {M, 5'd3, 5'd2, 5'd7, 5'd6, 5'd8}) $display("FAIL codes_min got %h want %h", bus6.digit_codes, {M, 5'd3, 5'd2, 5'd7, 5'd6, 5'd8}); else passed++;
    total++; if (bus6.ovf !== 1'b0) $display("FAIL ovf_min got %b want 0", bus6.ovf); else passed++;
    run(1'b0, 16'h7FFF, lat, bc);
    total++; if (bus6.digit_codes !== {B, 5'd3, 5'd2, 5'd7, 5'd6, 5'd7}) $display("FAIL codes_max got %h want %h", bus6.digit_codes, {B, 5'd3, 5'd2, 5'd7, 5'd6, 5'd7}); else passed++;
  endtask
  task automatic test_four_digits;
    int lat, bc;
    run(1'b1, 16'd9999, lat, bc);
    total++; if (lat != 17) $display("FAIL latency4 got %0d want 17", lat); else passed++;
    total++; if ({bus4.digit_codes, bus4.ovf} !== {5'd9, 5'd9, 5'd9, 5'd9, 1'b0}) $display("FAIL codes4_9999 got %h/%b want %h/0", bus4.digit_codes, bus4.ovf, {5'd9, 5'd9, 5'd9, 5'd9}); else passed++;
    run(1'b1, -16'sd1000, lat, bc);
    total++; if ({bus4.digit_codes, bus4.ovf} !== {M, M, M, M, 1'b1}) $display("FAIL codes4_m1000 got %h/%b want %h/1", bus4.digit_codes, bus4.ovf, {M, M, M, M}); else passed++;
    run(1'b1, 16'd7, lat, bc);
    total++; if ({bus4.digit_codes, bus4.ovf} !== {B, B, B, 5'd7, 1'b0}) $display("FAIL codes4_7 got %h/%b want %h/0", bus4.digit_codes, bus4.ovf, {B, B, B, 5'd7}); else passed++;
  endtask
  task automatic test_ignore_start;
    int dones = 0;
    @(negedge clk);
    bus6.start = 1'b1;
    bus6.value = 16'd321;
    @(posedge clk);
    #1;
    bus6.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus6.start = 1'b1;
    bus6.value = 16'd999;
    @(posedge clk);
    #1;
    bus6.start = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      dones += int'(bus6.done);
    end
    total++; if (dones != 1) $display("FAIL single_done got %0d want 1", dones); else passed++;
    total++; if (bus6.digit_codes !== {B, B, B, 5'd3, 5'd2, 5'd1}) $display("FAIL codes_321 got %h want %h", bus6.digit_codes, {B, B, B, 5'd3, 5'd2, 5'd1}); else passed++;
  endtask
  task automatic test_reset_abort;
    int dones = 0;
    int lat, bc;
    @(negedge clk);
    bus6.start = 1'b1;
    bus6.value = 16'd4321;
    @(posedge clk);
    #1;
    bus6.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus6.digit_codes !== {6{B}}) $display("FAIL abort_codes got %h want %h", bus6.digit_codes, {6{B}}); else passed++;
    total++; if ({bus6.busy, bus6.done} !== 2'b00) $display("FAIL abort_flags busy/done got %b want 00", {bus6.busy, bus6.done}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      dones += int'(bus6.done);
    end
    total++; if (dones != 0) $display("FAIL abort_no_done got %0d want 0", dones); else passed++;
    run(1'b0, 16'd55, lat, bc);
    total++; if (lat != 17 || bus6.digit_codes !== {B, B, B, B, 5'd5, 5'd5}) $display("FAIL after_abort lat %0d codes %h want 17 %h", lat, bus6.digit_codes, {B, B, B, B, 5'd5, 5'd5}); else passed++;
  endtask
  task automatic test_back_to_back;
    int lat = 0;
    @(negedge clk);
    bus6.start = 1'b1;
    bus6.value = 16'd12;
    @(posedge clk);
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus6.done) break;
    end
    total++; if (lat != 17 || bus6.digit_codes !== {B, B, B, B, 5'd1, 5'd2}) $display("FAIL b2b_first lat %0d codes %h want 17 %h", lat, bus6.digit_codes, {B, B, B, B, 5'd1, 5'd2}); else passed++;
    bus6.value = 16'd56;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus6.done) break;
    end
    bus6.start = 1'b0;
    total++; if (lat != 18 || bus6.digit_codes !== {B, B, B, B, 5'd5, 5'd6}) $display("FAIL b2b_second lat %0d codes %h want 18 %h", lat, bus6.digit_codes, {B, B, B, B, 5'd5, 5'd6}); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus6.busy !== 1'b0) $display("FAIL b2b_stop busy got %b want 0", bus6.busy); else passed++;
  endtask
  initial begin
    bus6.start = 1'b0;
    bus6.value = '0;
    bus4.start = 1'b0;
    bus4.value = '0;
    test_reset;
    test_basic;
    test_sign_zero;
    test_extremes;
    test_four_digits;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
